// File: rtl/sdspi_pkg.sv
// ---------------------------------------------------------------------------
// sdspi_pkg
//   Shared constants and types for the SD-over-SPI receive data path.
//   - CRC_POLYNOMIAL : CRC-16 (CCITT) generator used on data blocks
//   - START_TOKEN    : single-block data start token
//   - IDLE_BYTE      : value clocked on MOSI while reading / card idle fill
//   - state_t        : receive sequencer states
//   - crc16_byte     : one-byte MSB-first CRC-16 update, init/no reflection
// ---------------------------------------------------------------------------
package sdspi_pkg;

    localparam logic [15:0] CRC_POLYNOMIAL = 16'h1021;
    localparam logic [7:0]  START_TOKEN    = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE      = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        TOKEN,
        DATA,
        CRC_HI,
        CRC_LO,
        DONE
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  din);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ din[3'(7 - i)])
                c = {c[14:0], 1'b0} ^ CRC_POLYNOMIAL;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/spirxdata_if.sv
// ---------------------------------------------------------------------------
// spirxdata_if
//   Bundles the two buses of the SPI block receiver:
//   - low-level SPI byte engine : o_ll_stb/i_ll_busy request handshake,
//     o_ll_byte transmit byte, i_ll_stb/i_ll_byte received byte
//   - buffer memory write port  : o_write, o_addr[AW], o_data[DW]
//   Signal names carry the receiver's point of view (o_ = driven by it).
//   modport master : the receiver (spirxdata)
//   modport slave  : the byte engine plus buffer memory
// ---------------------------------------------------------------------------
interface spirxdata_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          o_ll_stb;
    logic          i_ll_busy;
    logic [7:0]    o_ll_byte;
    logic          i_ll_stb;
    logic [7:0]    i_ll_byte;
    logic          o_write;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    modport master (
        output o_ll_stb, o_ll_byte, o_write, o_addr, o_data,
        input  i_ll_busy, i_ll_stb, i_ll_byte
    );

    modport slave (
        input  o_ll_stb, o_ll_byte, o_write, o_addr, o_data,
        output i_ll_busy, i_ll_stb, i_ll_byte
    );
endinterface

// File: rtl/sdcrc16.sv
// ---------------------------------------------------------------------------
// sdcrc16
//   Byte-wise CRC-16 (poly 0x1021, init 0, MSB first, no reflection).
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset, clears the CRC
//   i_clear   : synchronous clear to 0 (takes priority over i_en)
//   i_en      : fold i_byte into the CRC this cycle
//   i_byte    : data byte
//   o_crc     : current CRC state
// ---------------------------------------------------------------------------
module sdcrc16
    import sdspi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_crc <= '0;
        else if (i_clear)
            o_crc <= '0;
        else if (i_en)
            o_crc <= crc16_byte(o_crc, i_byte);
    end

endmodule

// File: rtl/spirxdata.sv
// ---------------------------------------------------------------------------
// spirxdata
//   Receives one SD data block over a byte-wide SPI engine: waits for the
//   start token, packs 2^lgblksz data bytes into DW-bit words written to a
//   buffer, then checks the trailing CRC-16.
//
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_start          : begin a block read (ignored while busy)
//   i_lgblksz        : log2 of block size in bytes (3..9)
//   i_fifo           : buffer select, becomes MSB of the write address
//   o_busy           : transfer in progress
//   bus              : spirxdata_if.master (byte engine + buffer write port)
//   o_done           : one-cycle completion pulse
//   o_err            : bad token / CRC mismatch / timeout, held to next start
//   o_response       : last token byte seen
//
//   Optional: `define SPIRXDATA_TIMEOUT_EN to abort after TIMEOUT_BYTES
//   consecutive 0xFF bytes while waiting for the start token.
// ---------------------------------------------------------------------------
module spirxdata
    import sdspi_pkg::*;
#(
    parameter int          DW                = 32,
    parameter int          AW                = 8,
    parameter logic        OPT_LITTLE_ENDIAN = 1'b0,
    parameter logic [15:0] TIMEOUT_BYTES     = 16'd4096
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [3:0]          i_lgblksz,
    input  logic                i_fifo,
    output logic                o_busy,
    spirxdata_if.master         bus,
    output logic                o_done,
    output logic                o_err,
    output logic [7:0]          o_response
);

    localparam logic [AW-2:0] ADDR_ONE = 1;

    state_t        state;
    logic          pending;     // a byte request was accepted, reply not yet seen
    logic [3:0]    lgblksz;
    logic [9:0]    byte_cnt;
    logic [9:0]    last_byte;
    logic [DW-1:0] gear;
    logic [DW-1:0] gear_next;
    logic [7:0]    crc_hi;
    logic [15:0]   crc;
    logic          rx;
    logic [7:0]    rx_byte;
    logic          active;

`ifdef SPIRXDATA_TIMEOUT_EN
    logic [15:0]   tmo_cnt;
`else
    logic          unused_timeout;
    assign unused_timeout = ^TIMEOUT_BYTES;
`endif

    // Replies arriving with nothing outstanding are dropped here.
    assign rx        = pending && bus.i_ll_stb;
    assign rx_byte   = bus.i_ll_byte;
    assign bus.o_ll_byte = IDLE_BYTE;
    assign last_byte = 10'((16'd1 << lgblksz) - 16'd1);
    assign active    = state inside {TOKEN, DATA, CRC_HI, CRC_LO};

    always_comb begin
        gear_next = gear;
        if (OPT_LITTLE_ENDIAN)
            gear_next = {rx_byte, gear[DW-1:8]};
        else
            gear_next = {gear[DW-9:0], rx_byte};
    end

    sdcrc16 u_crc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   ((state == IDLE) && i_start),
        .i_en      (rx && (state == DATA)),
        .i_byte    (rx_byte),
        .o_crc     (crc)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            pending      <= 1'b0;
            lgblksz      <= '0;
            byte_cnt     <= '0;
            gear         <= '0;
            crc_hi       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_response   <= '0;
            bus.o_ll_stb <= 1'b0;
            bus.o_write  <= 1'b0;
            bus.o_addr   <= '0;
            bus.o_data   <= '0;
`ifdef SPIRXDATA_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            bus.o_write <= 1'b0;
            o_done      <= 1'b0;

            // Address advances in the cycle the write is presented.
            if (bus.o_write)
                bus.o_addr[AW-2:0] <= bus.o_addr[AW-2:0] + ADDR_ONE;

            // One request in flight: raise, hold through busy, then wait
            // for the reply before asking again.
            if (bus.o_ll_stb) begin
                if (!bus.i_ll_busy) begin
                    bus.o_ll_stb <= 1'b0;
                    pending      <= 1'b1;
                end
            end else if (active && !pending) begin
                bus.o_ll_stb <= 1'b1;
            end
            if (rx)
                pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= TOKEN;
                        o_busy     <= 1'b1;
                        o_err      <= 1'b0;
                        bus.o_addr <= {i_fifo, {(AW-1){1'b0}}};
                        lgblksz    <= i_lgblksz;
                        byte_cnt   <= '0;
`ifdef SPIRXDATA_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                TOKEN: begin
                    if (rx) begin
                        if (rx_byte == IDLE_BYTE) begin
`ifdef SPIRXDATA_TIMEOUT_EN
                            if (tmo_cnt == TIMEOUT_BYTES - 16'd1) begin
                                state      <= DONE;
                                o_err      <= 1'b1;
                                o_response <= IDLE_BYTE;
                            end else begin
                                tmo_cnt <= tmo_cnt + 16'd1;
                            end
`endif
                        end else if (rx_byte == START_TOKEN) begin
                            o_response <= rx_byte;
                            state      <= DATA;
                        end else begin
                            o_response <= rx_byte;
                            o_err      <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DATA: begin
                    if (rx) begin
                        gear     <= gear_next;
                        byte_cnt <= byte_cnt + 10'd1;
                        if (byte_cnt[1:0] == 2'd3) begin
                            bus.o_write <= 1'b1;
                            bus.o_data  <= gear_next;
                        end
                        if (byte_cnt == last_byte)
                            state <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (rx) begin
                        crc_hi <= rx_byte;
                        state  <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (rx) begin
                        o_err <= ({crc_hi, rx_byte} != crc);
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spirxdata.md
SPIRXDATA -- requirements
Module: spirxdata

Interface
REQ-001 SHALL have parameter DW, default 32, memory word width (fixed at 32).
REQ-002 SHALL have parameter AW, default 8, memory address width.
REQ-003 SHALL have parameter OPT_LITTLE_ENDIAN, default 1'b0: byte-to-word packing order.
REQ-004 SHALL have parameter TIMEOUT_BYTES, default 16'd4096: start-token wait limit; used only under SPIRXDATA_TIMEOUT_EN.
REQ-005 SHALL have ports, clock and reset first:
  i_clk  in  1  sole clock
  i_reset_n  in  1  asynchronous, active-low reset
  i_start  in  1  begin block read
  i_lgblksz  in  4  log2 block bytes, legal 3..9
  i_fifo  in  1  target buffer select, becomes o_addr MSB
  o_busy  out  1  transfer in progress
  o_ll_stb  out  1  request one SPI byte exchange
  i_ll_busy  in  1  low-level engine cannot accept a request
  o_ll_byte  out  8  transmitted byte, constant 8'hFF
  i_ll_stb  in  1  received byte valid
  i_ll_byte  in  8  received byte
  o_write  out  1  memory write strobe
  o_addr  out  AW  write address
  o_data  out  DW  write data
  o_done  out  1  one-cycle completion pulse
  o_err  out  1  error flag, valid with o_done
  o_response  out  8  last token byte (8'hFE or error token)

Function
REQ-006 SHALL implement states IDLE, TOKEN, DATA, CRC_HI, CRC_LO, DONE.
REQ-007 IDLE: i_start=1 SHALL move to TOKEN, set o_busy, load o_addr={i_fifo,0}, latch i_lgblksz, clear CRC and byte count; i_start while busy SHALL be ignored.
REQ-008 SHALL keep at most one byte request outstanding: o_ll_stb asserts in TOKEN/DATA/CRC_* when none is outstanding, held until cycle with !i_ll_busy, then deasserts until i_ll_stb.
REQ-009 TOKEN: byte 8'hFF SHALL stay; 8'hFE SHALL go to DATA; any other byte SHALL latch o_response, set o_err, go to DONE.
REQ-010 DATA: each byte SHALL shift into gearbox; big-endian first byte to [31:24], little-endian first byte to [7:0].
REQ-011 On every 4th data byte, o_write SHALL pulse the next cycle with o_addr/o_data; o_addr[AW-2:0] SHALL increment after each write, wrapping modulo 2^(AW-1), MSB unchanged.
REQ-012 After 2^lgblksz data bytes, SHALL go to CRC_HI.
REQ-013 CRC: CRC-16 poly 16'h1021, init 0, no reflection, MSB-first, updated one byte per i_ll_stb in DATA only.
REQ-014 CRC_HI/CRC_LO SHALL capture received CRC high then low byte; CRC_LO byte SHALL go to DONE with o_err = (received != computed).
REQ-015 DONE: SHALL pulse o_done one cycle, clear o_busy same cycle, return IDLE; o_err held until next i_start.
REQ-016 o_response SHALL be 8'hFE after valid start token.
REQ-017 i_ll_stb with no request outstanding SHALL be ignored.

Reset
REQ-018 i_reset_n=0 SHALL force IDLE asynchronously, any state including mid-block; o_busy, o_ll_stb, o_write, o_done, o_err=0, o_addr=0, o_data=0, o_response=0, no partial word written.

Configuration
REQ-019 Macro SPIRXDATA_TIMEOUT_EN defined: TOKEN SHALL count received 8'hFF bytes; reaching TIMEOUT_BYTES SHALL go to DONE with o_err=1, o_response=8'hFF.
REQ-020 Macro undefined: TOKEN SHALL wait indefinitely, no counter synthesised.

Structure
REQ-021 Package sdspi_pkg SHALL hold CRC_POLYNOMIAL 16'h1021, START_TOKEN 8'hFE, state enum.
REQ-022 Byte-wise CRC update SHALL be sub-module sdcrc16 (8-bit in, 16-bit state, clear, enable).

Verification
REQ-023 lgblksz=3, FF,FF,FE, bytes 00..07, CRC 16'h??-correct, big-endian -> writes 0x00010203@0, 0x04050607@1, o_done, o_err=0.
REQ-024 Same, OPT_LITTLE_ENDIAN=1 -> writes 0x03020100@0, 0x07060504@1.
REQ-025 lgblksz=9, i_fifo=1, 512 bytes, CRC low byte flipped -> 128 writes 0x80..0xFF, o_err=1.
REQ-026 Token 8'h05 -> no writes, o_response=8'h05, o_err=1, o_done.
REQ-027 i_reset_n low after 6 data bytes -> one write only, o_busy=0, then new i_start succeeds.
REQ-028 SPIRXDATA_TIMEOUT_EN, TIMEOUT_BYTES=16, only FF -> o_done after 16th byte, o_err=1, o_response=8'hFF.
